pid_sample_sequencer: RTL and testbench
=======================================

// Module: pid_sample_sequencer
// PURPOSE
//  Wishbone master that sequences one PID control step per sample strobe.
//  Per step: write new process value to pv (0x10), read u(n) from un (0x20), read OF (0x28).
//  Presents u(n) and overflow flags on a simple valid-qualified output.
//  Sits between the ADC sample front-end and the PID core's Wishbone slave port (32-bit data build).
// PARAMETERS
//  wb_nb      32      Wishbone data width (32-bit build only)
//  adr_wb_nb  16      Wishbone address width
//  PID_BASE   16'h0   byte base address of the PID slave
//  TO_CYC     255     max cycles stb may stay high without ack before abort (1..65535)
// PORTS
//  i_clk        in   1          clock
//  i_rst        in   1          asynchronous reset, active-low
//  i_sample_stb in   1          1-cycle pulse: new sample available on i_pv
//  i_pv         in   16         signed process value, sampled when i_sample_stb accepted
//  o_wb_cyc     out  1          Wishbone cycle
//  o_wb_stb     out  1          Wishbone strobe
//  o_wb_we      out  1          Wishbone write enable
//  o_wb_adr     out  adr_wb_nb  Wishbone byte address
//  o_wb_data    out  wb_nb      Wishbone write data
//  i_wb_ack     in   1          Wishbone acknowledge
//  i_wb_data    in   wb_nb      Wishbone read data
//  o_un         out  32         last completed u(n), held until next completion
//  o_of         out  5          OF[4:0] read in same step as o_un
//  o_un_valid   out  1          1-cycle pulse when o_un/o_of update
//  o_busy       out  1          high from accepted strobe until step completes or aborts
//  o_drop       out  1          1-cycle pulse: i_sample_stb ignored because busy
//  o_timeout    out  1          1-cycle pulse: step aborted on ack timeout
// BEHAVIOUR
//  Reset (async, i_rst=0): state IDLE; all outputs 0, timeout counter 0.
//  All outputs registered. FSM: IDLE -> WR_PV -> GAP1 -> RD_UN -> GAP2 -> RD_OF -> DONE -> IDLE.
//  IDLE: i_sample_stb=1 -> latch i_pv, o_busy<=1, go WR_PV. Else hold.
//  WR_PV: cyc=stb=we=1, adr=PID_BASE+0x10, data={{16{pv[15]}},pv}; hold until i_wb_ack.
//  RD_UN: cyc=stb=1, we=0, adr=PID_BASE+0x20. Slave withholds ack while update runs,
//   so ack arrives only when u(n) is final. On ack capture i_wb_data[31:0] into un shadow.
//  RD_OF: cyc=stb=1, we=0, adr=PID_BASE+0x28. On ack capture i_wb_data[4:0] into of shadow.
//  Ack sampled on rising edge with stb high ends the access; cyc/stb drop next cycle.
//  GAP1/GAP2: cyc=stb=0 for exactly 1 cycle so slave write-ack clears before next access.
//  DONE: o_un<=un shadow, o_of<=of shadow, o_un_valid=1 for one cycle, o_busy<=0, go IDLE.
//  Latency, zero-wait slave: strobe to o_un_valid = access cycles + 2 gaps + DONE.
//  i_sample_stb while o_busy (incl. DONE cycle): ignored, o_drop pulses, no state change.
//  Timeout: 16-bit counter clears on entry to each access state, increments each stb-high
//   cycle without ack. At count==TO_CYC-1 with no ack: drop cyc/stb, pulse o_timeout,
//   o_busy<=0, go IDLE; o_un/o_of keep old values, no o_un_valid.
//  Ack in same cycle counter hits limit: ack wins, no timeout.
//  i_wb_ack while cyc=0 or in GAP/IDLE/DONE: ignored.
//  Reset mid-access: cyc/stb drop asynchronously; shadows discarded.
// TESTING
//  1 Zero-wait model slave, i_pv=16'h0064 strobe -> write 0x10 data 0x00000064,
//    read 0x20, read 0x28, each separated by 1 idle cycle; o_un_valid once, o_busy low after.
//  2 Slave returns un=0xFFFFFF38, OF=5'h08, ack on 20th stb cycle of un read
//    -> o_un=32'hFFFFFF38, o_of=5'h08, o_un_valid exactly 1 cycle.
//  3 Strobe during RD_UN -> o_drop pulse, single step completes, no extra write to 0x10.
//  4 TO_CYC=8, slave never acks pv write -> cyc/stb low after 8 stb cycles,
//    o_timeout pulse, o_un unchanged; next strobe runs full step normally.
//  5 Assert i_rst mid RD_UN -> cyc/stb/o_busy/o_un 0 immediately; after release idle
//    until strobe; late slave ack ignored.
//  6 Integrated with PID core (kp=1,ki=0,kd=0,sp=100): i_pv=40 -> o_un=60,
//    o_of=0; i_pv=-32768 (sp-pv overflows 16-bit) -> o_of[1]=1.

Source files
------------

// File: rtl/pid_sample_sequencer.sv
// ---------------------------------------------------------------------------
// pid_sample_sequencer
//
// Wishbone master that runs one PID control step for every accepted sample
// strobe:
//   1. write the new process value to the PID slave's pv register (base+0x10)
//   2. read u(n) from the un register (base+0x20)
//   3. read the overflow flags from the OF register (base+0x28)
// One idle cycle (cyc=stb=0) separates the accesses, so a slave whose
// write-ack is registered has cleared it before the next access starts.
// The completed u(n) and OF[4:0] are presented on a valid-qualified output.
//
// Handshake: an access starts with cyc=stb=1. It ends on the first rising
// edge where i_wb_ack is sampled high while stb is high. cyc/stb then drop
// on the next cycle. If the slave withholds ack for TO_CYC stb-high cycles,
// the step is abandoned instead. i_sample_stb is accepted only in IDLE. A
// strobe that arrives in any other state, DONE included, is dropped and
// reported on o_drop.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_sample_stb, i_pv  sample strobe and signed 16-bit process value
//   o_wb_*              Wishbone master outputs (cyc, stb, we, adr, data)
//   i_wb_ack, i_wb_data Wishbone slave response
//   o_un, o_of          last completed u(n) and OF[4:0], held between steps
//   o_un_valid          1-cycle pulse when o_un/o_of update
//   o_busy              high from the accepted strobe until the step ends
//   o_drop              1-cycle pulse: strobe ignored because busy
//   o_timeout           1-cycle pulse: step aborted on ack timeout
//   o_state             current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module pid_sample_sequencer #(
    parameter int                   wb_nb     = 32,
    parameter int                   adr_wb_nb = 16,
    parameter logic [adr_wb_nb-1:0] PID_BASE  = '0,
    parameter int                   TO_CYC    = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sample_stb,
    input  logic [15:0]          i_pv,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [adr_wb_nb-1:0] o_wb_adr,
    output logic [wb_nb-1:0]     o_wb_data,
    input  logic                 i_wb_ack,
    input  logic [wb_nb-1:0]     i_wb_data,
    output logic [31:0]          o_un,
    output logic [4:0]           o_of,
    output logic                 o_un_valid,
    output logic                 o_busy,
    output logic                 o_drop,
    output logic                 o_timeout,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_PV = 3'd1,
        S_GAP1  = 3'd2,
        S_RD_UN = 3'd3,
        S_GAP2  = 3'd4,
        S_RD_OF = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [adr_wb_nb-1:0] ADR_PV = adr_wb_nb'(PID_BASE + 32'h10);
    localparam logic [adr_wb_nb-1:0] ADR_UN = adr_wb_nb'(PID_BASE + 32'h20);
    localparam logic [adr_wb_nb-1:0] ADR_OF = adr_wb_nb'(PID_BASE + 32'h28);

    // The counter reads 0 in the first stb-high cycle, so reaching
    // TO_CYC-1 without ack means TO_CYC stb cycles have elapsed.
    localparam logic [15:0] TO_LIM = 16'(TO_CYC - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] to_cnt;
    logic [31:0] un_shadow;

    logic in_access;
    logic acked;
    logic to_hit;
    logic accept;
    logic drop;

    // ------------------------------------------------------------------
    // Next-state logic. cyc/stb are registered images of the state, so
    // being in an access state means stb is high this cycle. Ack is
    // therefore only honoured in the access states.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        in_access  = (state == S_WR_PV) || (state == S_RD_UN) ||
                     (state == S_RD_OF);
        acked      = in_access && i_wb_ack;
        // Ack in the limit cycle wins over the timeout.
        to_hit     = in_access && !i_wb_ack && (to_cnt == TO_LIM);
        accept     = (state == S_IDLE) && i_sample_stb;
        drop       = (state != S_IDLE) && i_sample_stb;

        case (state)
            S_IDLE: begin
                if (i_sample_stb) state_next = S_WR_PV;
            end
            S_WR_PV: begin
                if (acked)       state_next = S_GAP1;
                else if (to_hit) state_next = S_IDLE;
            end
            S_GAP1: state_next = S_RD_UN;
            S_RD_UN: begin
                if (acked)       state_next = S_GAP2;
                else if (to_hit) state_next = S_IDLE;
            end
            S_GAP2: state_next = S_RD_OF;
            S_RD_OF: begin
                if (acked)       state_next = S_DONE;
                else if (to_hit) state_next = S_IDLE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, timeout counter, shadow and registered outputs. Bus outputs
    // are computed from state_next so they line up with the state they
    // belong to while still coming straight from flops.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            to_cnt     <= '0;
            un_shadow  <= '0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_adr   <= '0;
            o_wb_data  <= '0;
            o_un       <= '0;
            o_of       <= '0;
            o_un_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_drop     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state <= state_next;

            // Cleared whenever the state changes, which covers entry to
            // every access state; counts only stb-high cycles with no ack.
            if (state_next != state)
                to_cnt <= '0;
            else if (in_access && !i_wb_ack)
                to_cnt <= to_cnt + 16'd1;

            o_wb_cyc <= (state_next == S_WR_PV) || (state_next == S_RD_UN) ||
                        (state_next == S_RD_OF);
            o_wb_stb <= (state_next == S_WR_PV) || (state_next == S_RD_UN) ||
                        (state_next == S_RD_OF);
            o_wb_we  <= (state_next == S_WR_PV);

            case (state_next)
                S_WR_PV: o_wb_adr <= ADR_PV;
                S_RD_UN: o_wb_adr <= ADR_UN;
                S_RD_OF: o_wb_adr <= ADR_OF;
                default: o_wb_adr <= '0;
            endcase

            // The write-data register doubles as the latch for i_pv: it is
            // loaded on the accepting edge and held through the write.
            if (accept)
                o_wb_data <= {{(wb_nb-16){i_pv[15]}}, i_pv};
            else if (state_next != S_WR_PV)
                o_wb_data <= '0;

            if ((state == S_RD_UN) && acked)
                un_shadow <= i_wb_data[31:0];

            // OF arrives on the edge that enters DONE, so it goes straight
            // to the output together with the held u(n) shadow. A timeout
            // leaves both outputs untouched.
            o_un_valid <= 1'b0;
            if ((state == S_RD_OF) && acked) begin
                o_un       <= un_shadow;
                o_of       <= i_wb_data[4:0];
                o_un_valid <= 1'b1;
            end

            o_busy    <= (state_next != S_IDLE);
            o_drop    <= drop;
            o_timeout <= to_hit;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pid_sample_sequencer
//
// Two instances: dut (TO_CYC=255) against a programmable-latency model
// slave that can also behave like a PID core (kp=1, ki=0, kd=0, sp=100),
// and dut8 (TO_CYC=8) against a simple slave with one ack-latency setting
// for the timeout scenarios.
// ---------------------------------------------------------------------------
module tb_pid_sample_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic        sample_stb = 1'b0;
  logic [15:0] pv = '0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_adr;
  logic [31:0] wb_wdata;
  logic        wb_ack;
  logic [31:0] wb_rdata = '0;
  logic [31:0] un;
  logic [4:0]  of_flags;
  logic        un_valid, busy, drop, timeout;
  logic [2:0]  dbg_state;

  logic ack_slv = 1'b0;
  logic force_ack = 1'b0;
  assign wb_ack = ack_slv | force_ack;

  pid_sample_sequencer #(.TO_CYC(255)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_sample_stb(sample_stb), .i_pv(pv),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_data(wb_wdata), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata),
    .o_un(un), .o_of(of_flags), .o_un_valid(un_valid), .o_busy(busy),
    .o_drop(drop), .o_timeout(timeout), .o_state(dbg_state)
  );

  // ---------------- timeout DUT signals ----------------
  logic        stb8 = 1'b0;
  logic [15:0] pv8 = '0;
  logic        cyc8, wstb8, we8;
  logic [15:0] adr8;
  logic [31:0] wdata8;
  logic        ack8 = 1'b0;
  logic [31:0] rdata8 = '0;
  logic [31:0] un8;
  logic [4:0]  of8;
  logic        valid8, busy8, drop8, timeout8;
  logic [2:0]  dbg_state8;

  pid_sample_sequencer #(.TO_CYC(8)) dut8 (
    .i_clk(clk), .i_rst(rst_n), .i_sample_stb(stb8), .i_pv(pv8),
    .o_wb_cyc(cyc8), .o_wb_stb(wstb8), .o_wb_we(we8), .o_wb_adr(adr8),
    .o_wb_data(wdata8), .i_wb_ack(ack8), .i_wb_data(rdata8),
    .o_un(un8), .o_of(of8), .o_un_valid(valid8), .o_busy(busy8),
    .o_drop(drop8), .o_timeout(timeout8), .o_state(dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] exp_q[$];
  logic [15:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  int          gap_q[$];

  // main slave settings: ack on the Nth stb cycle of each access (0 = never)
  int          w_pv = 1, w_un = 1, w_of = 1;
  logic [31:0] slv_un = '0;
  logic [4:0]  slv_of = '0;
  bit          pid_mode = 1'b0;
  logic [15:0] pv_reg = '0;

  int stb_run = 0, idle_run = 0;
  logic prev_stb = 1'b0;
  int valid_cnt = 0, drop_cnt = 0, to_cnt = 0;

  // timeout-slave settings and monitors
  int w8 = 1;
  int run8 = 0, stb8_cycles = 0, valid8_cnt = 0, to8_cnt = 0;

  // ---------------- main model slave + monitor ----------------
  always @(negedge clk) begin
    int need;
    int d;
    if (wb_cyc && wb_stb) begin
      stb_run = stb_run + 1;
      need = (wb_adr == 16'h10) ? w_pv : (wb_adr == 16'h20) ? w_un : w_of;
      if (need != 0 && stb_run >= need) begin
        ack_slv = 1'b1;
        log_adr.push_back(wb_adr);
        log_dat.push_back(wb_wdata);
        log_we.push_back(wb_we);
        if (wb_we) pv_reg = wb_wdata[15:0];
        if (pid_mode) begin
          d = 100 - int'($signed(pv_reg));
          wb_rdata = (wb_adr == 16'h20) ? d :
                     {27'd0, ((d > 32767) || (d < -32768)) ? 5'h02 : 5'h00};
        end else begin
          wb_rdata = (wb_adr == 16'h20) ? slv_un : {27'd0, slv_of};
        end
        stb_run = 0;
      end else begin
        ack_slv = 1'b0;
      end
    end else begin
      ack_slv = 1'b0;
      stb_run = 0;
    end
    if (wb_stb && !prev_stb) gap_q.push_back(idle_run);
    if (!wb_stb) idle_run = idle_run + 1; else idle_run = 0;
    prev_stb = wb_stb;
    if (un_valid) valid_cnt = valid_cnt + 1;
    if (drop) drop_cnt = drop_cnt + 1;
    if (timeout) to_cnt = to_cnt + 1;
  end

  // ---------------- timeout-instance slave + monitor ----------------
  always @(negedge clk) begin
    if (cyc8 && wstb8) begin
      run8 = run8 + 1;
      stb8_cycles = stb8_cycles + 1;
      if (w8 != 0 && run8 >= w8) begin
        ack8 = 1'b1;
        rdata8 = (adr8 == 16'h20) ? 32'h0000_1234 : 32'h0000_0003;
        run8 = 0;
      end else begin
        ack8 = 1'b0;
      end
    end else begin
      ack8 = 1'b0;
      run8 = 0;
    end
    if (valid8) valid8_cnt = valid8_cnt + 1;
    if (timeout8) to8_cnt = to8_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_stb(input logic [15:0] v);
    @(posedge clk); #1;
    pv = v;
    sample_stb = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
  endtask

  task automatic pulse_stb8(input logic [15:0] v);
    @(posedge clk); #1;
    pv8 = v;
    stb8 = 1'b1;
    @(posedge clk); #1;
    stb8 = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin @(negedge clk); k++; end
    #1;
    total_cnt++;
    if (busy) $display("FAIL %s_idle busy still 1 after %0d cycles", nm, budget);
    else pass_cnt++;
  endtask

  task automatic wait_idle8(input int budget, input string nm);
    int k = 0;
    @(negedge clk);
    while (busy8 && k < budget) begin @(negedge clk); k++; end
    #1;
    total_cnt++;
    if (busy8) $display("FAIL %s_idle busy8 still 1 after %0d cycles", nm, budget);
    else pass_cnt++;
  endtask

  task automatic wait_access(input logic [15:0] a, input int budget, input string nm);
    int k = 0;
    @(negedge clk);
    while (!(wb_stb && wb_adr == a) && k < budget) begin @(negedge clk); k++; end
    total_cnt++;
    if (!(wb_stb && wb_adr == a)) $display("FAIL %s_access no stb to %h in %0d cycles", nm, a, budget);
    else pass_cnt++;
  endtask

  task automatic clear_logs();
    log_adr.delete(); log_dat.delete(); log_we.delete(); gap_q.delete(); exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({wb_cyc, wb_stb, wb_we, un_valid, busy, drop, timeout} !== 7'b0 ||
        wb_adr !== 16'h0 || wb_wdata !== 32'h0 || un !== 32'h0 || of_flags !== 5'h0)
      $display("FAIL reset_outputs cyc=%b stb=%b adr=%h un=%h of=%h busy=%b exp all 0",
               wb_cyc, wb_stb, wb_adr, un, of_flags, busy);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", dbg_state);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (wb_cyc !== 1'b0 || busy !== 1'b0) $display("FAIL reset_release cyc=%b busy=%b exp 0 0", wb_cyc, busy);
    else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    int c = 0;
    int v0;
    w_pv = 1; w_un = 1; w_of = 1; slv_un = 32'h0000_0abc; slv_of = 5'h11;
    clear_logs();
    exp_q.push_back(16'h10); exp_q.push_back(16'h20); exp_q.push_back(16'h28);
    v0 = valid_cnt;
    pulse_stb(16'h0064);
    while (!un_valid && c < 30) begin @(negedge clk); c++; end
    total_cnt++;
    if (c != 6) $display("FAIL zw_latency got %0d cycles exp 6", c);
    else pass_cnt++;
    wait_idle(10, "zw");
    total_cnt++;
    if (log_adr.size() != 3 || log_adr != exp_q)
      $display("FAIL zw_addr_seq got %0d accesses exp 3 (0x10,0x20,0x28)", log_adr.size());
    else pass_cnt++;
    total_cnt++;
    if (log_dat.size() < 1 || log_dat[0] !== 32'h0000_0064 || log_we[0] !== 1'b1)
      $display("FAIL zw_write_data got %h exp 00000064 we=1", (log_dat.size() > 0) ? log_dat[0] : 32'hx);
    else pass_cnt++;
    total_cnt++;
    if (log_we.size() != 3 || log_we[1] !== 1'b0 || log_we[2] !== 1'b0)
      $display("FAIL zw_read_we reads must have we=0");
    else pass_cnt++;
    total_cnt++;
    if (gap_q.size() != 3 || gap_q[1] != 1 || gap_q[2] != 1)
      $display("FAIL zw_gaps got size %0d gaps %0d %0d exp 1 1", gap_q.size(),
               (gap_q.size() > 1) ? gap_q[1] : -1, (gap_q.size() > 2) ? gap_q[2] : -1);
    else pass_cnt++;
    total_cnt++;
    if (valid_cnt - v0 != 1) $display("FAIL zw_valid_count got %0d exp 1", valid_cnt - v0);
    else pass_cnt++;
    total_cnt++;
    if (un !== 32'h0000_0abc || of_flags !== 5'h11) $display("FAIL zw_result un=%h of=%h exp 00000abc 11", un, of_flags);
    else pass_cnt++;
  endtask

  task automatic test_slow_un();
    int v0;
    w_un = 20; slv_un = 32'hFFFF_FF38; slv_of = 5'h08;
    clear_logs();
    v0 = valid_cnt;
    pulse_stb(16'hFF9C);
    wait_idle(60, "slow");
    total_cnt++;
    if (un !== 32'hFFFF_FF38) $display("FAIL slow_un got %h exp ffffff38", un);
    else pass_cnt++;
    total_cnt++;
    if (of_flags !== 5'h08) $display("FAIL slow_of got %h exp 08", of_flags);
    else pass_cnt++;
    total_cnt++;
    if (valid_cnt - v0 != 1) $display("FAIL slow_valid_width got %0d cycles exp 1", valid_cnt - v0);
    else pass_cnt++;
    total_cnt++;
    if (log_dat.size() < 1 || log_dat[0] !== 32'hFFFF_FF9C)
      $display("FAIL slow_sign_ext got %h exp ffffff9c", (log_dat.size() > 0) ? log_dat[0] : 32'hx);
    else pass_cnt++;
    w_un = 1;
  endtask

  task automatic test_drop();
    int v0, d0, pvw;
    w_un = 10; slv_un = 32'h0000_0777; slv_of = 5'h01;
    clear_logs();
    v0 = valid_cnt; d0 = drop_cnt;
    pulse_stb(16'h0005);
    wait_access(16'h20, 20, "drop");
    sample_stb = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
    wait_idle(40, "drop");
    repeat (3) @(negedge clk);
    pvw = 0;
    foreach (log_adr[i]) if (log_adr[i] == 16'h10) pvw++;
    total_cnt++;
    if (drop_cnt - d0 != 1) $display("FAIL drop_pulse got %0d exp 1", drop_cnt - d0);
    else pass_cnt++;
    total_cnt++;
    if (pvw != 1) $display("FAIL drop_pv_writes got %0d exp 1", pvw);
    else pass_cnt++;
    total_cnt++;
    if (valid_cnt - v0 != 1 || un !== 32'h0000_0777) $display("FAIL drop_single_step valid=%0d un=%h exp 1 00000777", valid_cnt - v0, un);
    else pass_cnt++;
    w_un = 1;
  endtask

  task automatic test_done_drop();
    int c = 0;
    int d0;
    clear_logs();
    pulse_stb(16'h0001);
    while (!un_valid && c < 30) begin @(negedge clk); c++; end
    d0 = drop_cnt;
    sample_stb = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (drop_cnt - d0 != 1) $display("FAIL done_drop_pulse got %0d exp 1", drop_cnt - d0);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || log_adr.size() != 3) $display("FAIL done_drop_ignored busy=%b accesses=%0d exp 0 3", busy, log_adr.size());
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    w8 = 1;
    pulse_stb8(16'h0010);
    wait_idle8(20, "to_first");
    total_cnt++;
    if (un8 !== 32'h0000_1234 || of8 !== 5'h03 || valid8_cnt != 1)
      $display("FAIL to_first_step un=%h of=%h valid=%0d exp 00001234 03 1", un8, of8, valid8_cnt);
    else pass_cnt++;
    // never ack: abort after 8 stb cycles
    w8 = 0; stb8_cycles = 0;
    pulse_stb8(16'h0020);
    wait_idle8(40, "to_never");
    total_cnt++;
    if (stb8_cycles != 8) $display("FAIL to_stb_cycles got %0d exp 8", stb8_cycles);
    else pass_cnt++;
    total_cnt++;
    if (to8_cnt != 1 || cyc8 !== 1'b0) $display("FAIL to_pulse got %0d cyc=%b exp 1 0", to8_cnt, cyc8);
    else pass_cnt++;
    total_cnt++;
    if (un8 !== 32'h0000_1234 || valid8_cnt != 1) $display("FAIL to_un_kept un=%h valid=%0d exp 00001234 1", un8, valid8_cnt);
    else pass_cnt++;
    // ack on the 8th stb cycle: ack wins
    w8 = 8;
    pulse_stb8(16'h0030);
    wait_idle8(60, "to_edge");
    total_cnt++;
    if (to8_cnt != 1 || valid8_cnt != 2) $display("FAIL to_ack_wins timeouts=%0d valid=%0d exp 1 2", to8_cnt, valid8_cnt);
    else pass_cnt++;
    // ack on the 9th: too late
    w8 = 9;
    pulse_stb8(16'h0040);
    wait_idle8(60, "to_late");
    total_cnt++;
    if (to8_cnt != 2 || valid8_cnt != 2) $display("FAIL to_late_ack timeouts=%0d valid=%0d exp 2 2", to8_cnt, valid8_cnt);
    else pass_cnt++;
    w8 = 1;
    pulse_stb8(16'h0050);
    wait_idle8(20, "to_recover");
    total_cnt++;
    if (valid8_cnt != 3 || to8_cnt != 2) $display("FAIL to_recover valid=%0d timeouts=%0d exp 3 2", valid8_cnt, to8_cnt);
    else pass_cnt++;
  endtask

  task automatic test_pid_model();
    pid_mode = 1'b1;
    pulse_stb(16'd40);
    wait_idle(20, "pid_pos");
    total_cnt++;
    if (un !== 32'd60 || of_flags !== 5'h00) $display("FAIL pid_pv40 un=%0d of=%h exp 60 00", un, of_flags);
    else pass_cnt++;
    pulse_stb(16'h8000);
    wait_idle(20, "pid_ovf");
    total_cnt++;
    if (of_flags !== 5'h02) $display("FAIL pid_overflow of=%h exp 02", of_flags);
    else pass_cnt++;
    pid_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    int v0;
    w_un = 50;
    pulse_stb(16'h0007);
    wait_access(16'h20, 20, "rst_mid");
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || busy !== 1'b0 || un !== 32'h0)
      $display("FAIL rst_mid_async cyc=%b stb=%b busy=%b un=%h exp 0 0 0 0", wb_cyc, wb_stb, busy, un);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w_un = 1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (wb_cyc !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_idle cyc=%b busy=%b exp 0 0", wb_cyc, busy);
    else pass_cnt++;
    v0 = valid_cnt;
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (wb_cyc !== 1'b0 || dbg_state !== 3'd0 || valid_cnt != v0 || un !== 32'h0)
      $display("FAIL rst_mid_late_ack cyc=%b state=%0d valid=%0d un=%h exp 0 0 0 0", wb_cyc, dbg_state, valid_cnt - v0, un);
    else pass_cnt++;
    slv_un = 32'h0000_5555; slv_of = 5'h04;
    pulse_stb(16'h0009);
    wait_idle(20, "rst_after");
    total_cnt++;
    if (un !== 32'h0000_5555 || of_flags !== 5'h04 || valid_cnt - v0 != 1)
      $display("FAIL rst_after_step un=%h of=%h exp 00005555 04", un, of_flags);
    else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_zero_wait();
    test_slow_un();
    test_drop();
    test_done_drop();
    test_timeout();
    test_pid_model();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
